// File: rtl/serial_operand_loader.sv
// Serial byte stream to operand memory loader.
// Packs bytes into memory words and publishes operand 0 per frame.
module serial_operand_loader #(
  parameter int N         = 64,
  parameter int DBITS     = 64,
  parameter int ABITS     = 8,
  parameter int NUM_OPS   = 2,
  parameter int BASE_ADDR = 0,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 rx_ready,
  output logic [ABITS-1:0]     wr_addr,
  output logic [DBITS-1:0]     wr_data,
  output logic                 wr_en,
  output logic [N-1:0]         tx_e,
  output logic [$clog2(N)-1:0] tx_e_idx,
  output logic                 tx_valid,
  output logic                 tx_err
);

  localparam int IW  = $clog2(N);
  localparam int BPW = DBITS / 8;
  localparam int WPO = N / DBITS;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WW  = (WPO > 1) ? $clog2(WPO) : 1;
  localparam int OW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [BW-1:0] LAST_B = BW'(BPW - 1);
  localparam logic [WW-1:0] LAST_W = WW'(WPO - 1);
  localparam logic [OW-1:0] LAST_O = OW'(NUM_OPS - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]       state;
  logic [BW-1:0]    b_cnt;
  logic [WW-1:0]    w_cnt;
  logic [OW-1:0]    o_cnt;
  logic [TW-1:0]    idle_cnt;
  logic [DBITS-1:0] word;
  logic [N-1:0]     shadow;

  logic             accept;
  logic             word_end;
  logic             op_end;
  logic             frame_end;
  logic             timeout;
  logic [WW-1:0]    w_idx;
  logic [DBITS-1:0] word_nx;
  logic [N-1:0]     shadow_nx;
  logic [ABITS-1:0] addr_nx;
  logic [IW-1:0]    hi_idx;

  assign rx_ready  = (state == IDLE) || (state == RECV);
  assign accept    = rx_valid && rx_ready;
  assign word_end  = accept && (b_cnt == LAST_B);
  assign op_end    = word_end && (w_cnt == LAST_W);
  assign frame_end = op_end && (o_cnt == LAST_O);
  assign timeout   = (state == RECV) && !accept && (idle_cnt == LAST_T);

  // Byte order decides both the shift direction and the word walk order.
  always_comb begin
    if (MSB_FIRST != 0) begin
      word_nx   = (word << 8) | DBITS'(rx_byte);
      shadow_nx = (shadow << 8) | N'(rx_byte);
      w_idx     = LAST_W - w_cnt;
    end else begin
      word_nx   = (word >> 8) | (DBITS'(rx_byte) << (DBITS - 8));
      shadow_nx = (shadow >> 8) | (N'(rx_byte) << (N - 8));
      w_idx     = w_cnt;
    end
  end

  assign addr_nx = ABITS'(BASE_ADDR)
                 + ABITS'(o_cnt) * ABITS'(WPO)
                 + ABITS'(w_idx);

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (shadow[i]) hi_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      b_cnt    <= '0;
      w_cnt    <= '0;
      o_cnt    <= '0;
      idle_cnt <= '0;
      word     <= '0;
      shadow   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      tx_e     <= '0;
      tx_e_idx <= '0;
      tx_valid <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      tx_valid <= 1'b0;
      tx_err   <= 1'b0;
      unique case (state)
        IDLE, RECV: begin
          if (accept) begin
            word     <= word_nx;
            idle_cnt <= '0;
            if (o_cnt == '0) shadow <= shadow_nx;
            b_cnt <= word_end ? '0 : b_cnt + 1'b1;
            if (op_end) w_cnt <= '0;
            else if (word_end) w_cnt <= w_cnt + 1'b1;
            if (frame_end) o_cnt <= '0;
            else if (op_end) o_cnt <= o_cnt + 1'b1;
            if (word_end) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_nx;
              wr_data <= word_nx;
            end
            state <= frame_end ? DONE : RECV;
          end else if (timeout) begin
            // Drop the partial word; words already written stay as is.
            state    <= ERR;
            tx_err   <= 1'b1;
            b_cnt    <= '0;
            w_cnt    <= '0;
            o_cnt    <= '0;
            idle_cnt <= '0;
            word     <= '0;
          end else if (state == RECV) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          tx_e     <= shadow;
          tx_e_idx <= hi_idx;
          tx_valid <= 1'b1;
          state    <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader.
// Runs MSB-first and LSB-first instances on a shared byte stream.
module tb_serial_operand_loader;

  localparam int N  = 64;
  localparam int DB = 32;
  localparam int AB = 8;
  localparam int NO = 2;
  localparam int TO = 16;

  typedef struct {
    logic [127:0] b;
    logic [63:0]  e1;
    int           i1;
    logic [63:0]  e0;
    int           i0;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rdy[2];
  logic [AB-1:0] wa[2];
  logic [DB-1:0] wd[2];
  logic          we[2];
  logic [N-1:0]  te[2];
  logic [5:0]    ti[2];
  logic          tv[2];
  logic          terr[2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cyc[2];
  int vcyc[2];
  int vcnt[2];
  int ecnt[2];
  logic [63:0] exp_e[2];
  logic [40:0] wq[$];
  logic [7:0]  sent[$];
  vec_t        vecs[4];

  always #5 clk = ~clk;

  serial_operand_loader #(
    .N(N), .DBITS(DB), .ABITS(AB), .NUM_OPS(NO),
    .BASE_ADDR(0), .MSB_FIRST(1), .TIMEOUT(TO)
  ) u_msb (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rdy[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .wr_en(we[1]),
    .tx_e(te[1]), .tx_e_idx(ti[1]), .tx_valid(tv[1]), .tx_err(terr[1])
  );

  serial_operand_loader #(
    .N(N), .DBITS(DB), .ABITS(AB), .NUM_OPS(NO),
    .BASE_ADDR(0), .MSB_FIRST(0), .TIMEOUT(TO)
  ) u_lsb (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rdy[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .wr_en(we[0]),
    .tx_e(te[0]), .tx_e_idx(ti[0]), .tx_valid(tv[0]), .tx_err(terr[0])
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (we[m]) begin
        wq.push_back({(m == 1), wa[m], wd[m]});
        wr_cyc[m] = cyc;
      end
      if (tv[m]) begin
        vcnt[m]++;
        vcyc[m] = cyc;
      end
      if (terr[m]) ecnt[m]++;
    end
    if (rx_valid && rdy[1]) acc_cyc = cyc;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] op_val(input int base, input bit msb);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (msb) v = v * 256 + 64'(sent[base + i]);
      else v = v + (64'(sent[base + i]) << (8 * i));
    end
    return v;
  endfunction

  function automatic int hi_bit(input logic [63:0] v);
    logic [63:0] t = v;
    int r = 0;
    while (t > 1) begin
      t = t >> 1;
      r++;
    end
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wq.delete();
    for (int m = 0; m < 2; m++) begin
      vcnt[m] = 0;
      ecnt[m] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_rdy%0d", tag, m), 64'(rdy[m]), 64'd1);
      chk($sformatf("%s_wen%0d", tag, m), 64'(we[m]), 64'd0);
      chk($sformatf("%s_vld%0d", tag, m), 64'(tv[m]), 64'd0);
      chk($sformatf("%s_err%0d", tag, m), 64'(terr[m]), 64'd0);
      chk($sformatf("%s_wa%0d", tag, m), 64'(wa[m]), 64'd0);
      chk($sformatf("%s_wd%0d", tag, m), 64'(wd[m]), 64'd0);
      chk($sformatf("%s_te%0d", tag, m), te[m], 64'd0);
      chk($sformatf("%s_ti%0d", tag, m), 64'(ti[m]), 64'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    while (!rdy[1] && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", 64'(rdy[1]), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      send_byte(sent[i]);
      if (gap > 0) begin
        repeat ($urandom_range(gap, 0)) sync();
      end
    end
  endtask

  task automatic wait_done(input int nfr);
    int n = 0;
    while (vcnt[1] < nfr && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_frames(input int nfr);
    sent.delete();
    for (int i = 0; i < 16 * nfr; i++) sent.push_back(8'($urandom));
  endtask

  task automatic verify(input string tag);
    int nfr;
    int w;
    logic [40:0] exp[$];
    logic [40:0] act[$];
    logic [63:0] v;
    nfr = sent.size() / 16;
    for (int m = 0; m < 2; m++) begin
      exp.delete();
      act.delete();
      for (int f = 0; f < nfr; f++) begin
        for (int k = 0; k < 2; k++) begin
          v = op_val(f * 16 + k * 8, m == 1);
          for (int j = 0; j < 2; j++) begin
            w = (m == 1) ? 1 - j : j;
            exp.push_back({(m == 1), 8'(k * 2 + w), v[32 * w +: 32]});
          end
        end
      end
      foreach (wq[i]) if (wq[i][40] == (m == 1)) act.push_back(wq[i]);
      chk($sformatf("%s_nwr_m%0d", tag, m), 64'(act.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < act.size(); i++)
        chk($sformatf("%s_wr%0d_m%0d", tag, i, m), 64'(act[i]), 64'(exp[i]));
      v = op_val((nfr - 1) * 16, m == 1);
      chk($sformatf("%s_te_m%0d", tag, m), te[m], v);
      chk($sformatf("%s_ti_m%0d", tag, m), 64'(ti[m]), 64'(hi_bit(v)));
      chk($sformatf("%s_nvld_m%0d", tag, m), 64'(vcnt[m]), 64'(nfr));
      chk($sformatf("%s_nerr_m%0d", tag, m), 64'(ecnt[m]), 64'd0);
      exp_e[m] = v;
    end
  endtask

  task automatic load_vec(input int vi);
    sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back(vecs[vi].b[127 - 8 * i -: 8]);
  endtask

  task automatic chk_vec(input string tag, input int vi);
    chk({tag, "_tbl_e1"}, te[1], vecs[vi].e1);
    chk({tag, "_tbl_i1"}, 64'(ti[1]), 64'(vecs[vi].i1));
    chk({tag, "_tbl_e0"}, te[0], vecs[vi].e0);
    chk({tag, "_tbl_i0"}, 64'(ti[0]), 64'(vecs[vi].i0));
  endtask

  initial begin
    int idx;
    int refused;
    int n;
    vecs[0] = '{128'h0102030405060708_090A0B0C0D0E0F10,
                64'h0102030405060708, 56, 64'h0807060504030201, 59};
    vecs[1] = '{128'h0000000000000000_A1B2C3D4E5F60718,
                64'h0, 0, 64'h0, 0};
    vecs[2] = '{128'h8000000000000001_FFFFFFFFFFFFFFFF,
                64'h8000000000000001, 63, 64'h0100000000000080, 56};
    vecs[3] = '{128'h00000000000000FF_5A5A5A5A5A5A5A5A,
                64'h00000000000000FF, 7, 64'hFF00000000000000, 63};
    exp_e[0] = 64'd0;
    exp_e[1] = 64'd0;
    clear();

    repeat (2) @(negedge clk);
    chk_zero("reset");
    sync();
    rst = 1'b0;
    sync();

    for (int vi = 0; vi < 4; vi++) begin
      clear();
      load_vec(vi);
      send_range(0, 16, 0);
      wait_done(1);
      verify($sformatf("vec%0d", vi));
      chk_vec($sformatf("vec%0d", vi), vi);
      if (vi == 0) begin
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("vld_lat_m%0d", m), 64'(vcyc[m] - acc_cyc), 64'd2);
          chk($sformatf("wr_lat_m%0d", m), 64'(wr_cyc[m] - acc_cyc), 64'd1);
        end
      end
      sync();
    end

    // 15 idle cycles mid-frame stays just under the timeout.
    clear();
    rand_frames(1);
    send_range(0, 7, 0);
    repeat (15) sync();
    send_range(7, 16, 0);
    wait_done(1);
    verify("gap15");
    sync();

    clear();
    sent.delete();
    for (int i = 0; i < 5; i++) sent.push_back(8'(8'h11 + i));
    send_range(0, 5, 0);
    repeat (22) @(negedge clk);
    chk("to_nwr", 64'(wq.size()), 64'd2);
    foreach (wq[i]) begin
      if (wq[i][40]) chk("to_wr_m1", 64'(wq[i]), {23'd0, 1'b1, 8'd1, 32'h11121314});
      else chk("to_wr_m0", 64'(wq[i]), {23'd0, 1'b0, 8'd0, 32'h14131211});
    end
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("to_nerr_m%0d", m), 64'(ecnt[m]), 64'd1);
      chk($sformatf("to_nvld_m%0d", m), 64'(vcnt[m]), 64'd0);
      chk($sformatf("to_te_m%0d", m), te[m], exp_e[m]);
    end
    sync();
    clear();
    rand_frames(1);
    send_range(0, 16, 0);
    wait_done(1);
    verify("after_to");
    sync();

    clear();
    load_vec(0);
    send_range(0, 9, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_nerr1", 64'(ecnt[1]), 64'd0);
    chk("midrst_nerr0", 64'(ecnt[0]), 64'd0);
    sync();
    rst = 1'b0;
    sync();
    clear();
    send_range(0, 16, 0);
    wait_done(1);
    verify("postrst");
    chk_vec("postrst", 0);
    sync();

    // Valid held high across two frames: one byte refused in DONE.
    clear();
    rand_frames(2);
    idx = 0;
    refused = 0;
    n = 0;
    rx_valid = 1'b1;
    while (idx < 32 && n < 100) begin
      rx_byte = sent[idx];
      @(negedge clk);
      if (rdy[1]) idx++;
      else refused++;
      sync();
      n++;
    end
    rx_valid = 1'b0;
    wait_done(2);
    chk("b2b_sent", 64'(idx), 64'd32);
    chk("b2b_refused", 64'(refused), 64'd1);
    verify("b2b");
    sync();

    for (int r = 0; r < 6; r++) begin
      clear();
      rand_frames(1);
      send_range(0, 16, 3);
      wait_done(1);
      verify($sformatf("rnd%0d", r));
      sync();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
